// File: rtl/alu_op_queue.sv
// alu_op_queue: small FIFO of ALU operations (A, B, FuncCode) between decode
// and the 16-bit ALU. The head entry drives the ALU inputs directly; both
// sides use valid/ready handshakes. Empty queue presents zeros to the ALU.
module alu_op_queue #(
  parameter int data_width = 16,
  parameter int depth      = 4,   // power of two, 2..16
  parameter int ptr_width  = 2    // log2(depth)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_A,
  input  logic [data_width-1:0] in_B,
  input  logic [3:0]            in_func,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] A,
  output logic [data_width-1:0] B,
  output logic [3:0]            FuncCode,
  output logic [ptr_width:0]    count
);

  typedef struct packed {
    logic [data_width-1:0] opA;
    logic [data_width-1:0] opB;
    logic [3:0]            func;
  } entry_t;

  localparam logic [ptr_width:0]   fullCount = (ptr_width + 1)'(depth);
  localparam logic [ptr_width:0]   countOne  = (ptr_width + 1)'(1);
  localparam logic [ptr_width-1:0] ptrOne    = ptr_width'(1);

  entry_t                mem [0:depth-1];
  entry_t                headEntry;
  logic [ptr_width-1:0]  rdPtr;
  logic [ptr_width-1:0]  wrPtr;
  logic                  pushEn;
  logic                  popEn;

  // Handshake flags depend only on occupancy, so a full queue refuses a push
  // even when a pop happens in the same cycle.
  assign in_ready  = (count != fullCount);
  assign out_valid = (count != '0);
  assign pushEn    = in_valid && in_ready;
  assign popEn     = out_valid && out_ready;

  // Head selection: the stored entry at the read pointer, or zeros when empty
  // so the ALU sees FuncCode 0 with zero operands.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    headEntry = '0;
    if (out_valid) begin
      headEntry = mem[rdPtr];
    end
  end

  assign A        = headEntry.opA;
  assign B        = headEntry.opB;
  assign FuncCode = headEntry.func;

  // Storage write on an accepted push; a flush in the same cycle drops it.
  // NOTE: the storage array has no reset; occupancy tracking makes stale
  // contents invisible, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (pushEn && !flush) begin
      mem[wrPtr] <= '{opA: in_A, opB: in_B, func: in_func};
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + ptrOne;
      end
      if (popEn) begin
        rdPtr <= rdPtr + ptrOne;
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + countOne;
        2'b01:   count <= count - countOne;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/alu_op_queue.md
Name: alu_op_queue

Overview:
- Operand/opcode issue queue sitting directly upstream of the 16-bit ALU.
- Buffers ALU operations (A, B, FuncCode) from the decode side in a small FIFO.
- Presents the oldest operation on outputs wired straight to the ALU's A, B and FuncCode inputs.
- Uses valid/ready handshakes on both sides so decode can run ahead of result consumption.

Parameters:
- data_width, 16, width of A and B; must match the ALU.
- depth, 4, number of queue entries; power of two, 2 to 16.
- ptr_width, 2, log2(depth); set consistently with depth.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all entries, active high
- in_valid  input  1  decode presents an operation
- in_ready  output  1  queue can accept this cycle
- in_A  input  data_width  operand A
- in_B  input  data_width  operand B
- in_func  input  4  FuncCode, carried unmodified
- out_valid  output  1  head entry valid toward the ALU side
- out_ready  input  1  consumer takes head this cycle
- A  output  data_width  head operand A, to ALU A
- B  output  data_width  head operand B, to ALU B
- FuncCode  output  4  head FuncCode, to ALU FuncCode
- count  output  ptr_width+1  number of occupied entries, 0..depth

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset state:
  - Read pointer, write pointer and count are 0.
  - out_valid=0 and in_ready=1.
  - A, B and FuncCode read 0.
  - Storage contents need not be cleared.
- Push: occurs on a rising edge when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments modulo depth.
- Pop: occurs on a rising edge when out_valid && out_ready. The read pointer increments modulo depth.
- Latency: an entry pushed into an empty queue appears on A/B/FuncCode, with out_valid=1, in the cycle after the push edge. There is no same-cycle bypass from input to output.
- Output path: A/B/FuncCode come from the storage entry at the read pointer (register output, no combinational path from in_*).
- Empty output: when count==0, A, B and FuncCode are forced to 0 so the ALU sees FuncCode 4'h0 with zero operands.
- Ready/valid decode:
  - in_ready = (count != depth). It depends only on state, never on out_ready, so a full queue refuses a push even when a pop happens the same cycle.
  - out_valid = (count != 0).
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointer wrap-around: pointers wrap from depth-1 to 0. Order is strictly FIFO across the wrap.
- Flush:
  - On an edge with flush=1, pointers and count go to 0. Any push or pop in that cycle is discarded.
  - The next cycle shows out_valid=0 and in_ready=1.
  - flush takes priority over push and pop.
- Reset during operation: asserting reset_n low at any time clears state immediately (asynchronously). Outputs go to their reset values without waiting for a clock edge. Deassertion is sampled by the next rising edge.
- Handshake stability: A/B/FuncCode hold stable while out_valid=1 && out_ready=0.
- Data handling: the queue never interprets FuncCode and never modifies data; all 16 FuncCode values pass through.

Test Plan:
- Reset, then push A=16'h0003, B=16'h0004, func=4'h0 with out_ready=0:
  - Cycle after the push: out_valid=1, A=3, B=4, FuncCode=0, count=1.
  - Held unchanged for 5 further cycles.
- Fill to depth: push 4 entries A=1..4 with out_ready=0:
  - count=4, in_ready=0.
  - A 5th in_valid is ignored.
  - Popping 4 times then yields A=1,2,3,4 in order, then out_valid=0 and A=0.
- Full queue with in_valid=1 and out_ready=1 in the same cycle:
  - Only the pop happens, count goes 4 to 3.
  - Next cycle in_ready=1 and the push is accepted, count=4.
- Wrap-around: stream 10 entries with continuous push and pop while count is held at 2:
  - Output order matches input order A=16'h0010..16'h0019.
  - count stays 2 and no entry is duplicated.
- Flush with 3 entries present while in_valid=1 (A=16'h00FF):
  - Next cycle count=0, out_valid=0 and A=0.
  - The 16'h00FF entry is not stored.
- Assert reset_n=0 mid-cycle with 2 entries queued:
  - out_valid, count and A go to 0 before the next clk edge.
  - After release, the first push appears one cycle later.
